ones_count_driver: RTL

//  Initiator side of the OnesCount d_in_ready/dor handshake. Accepts 30-bit words

---
 rtl/ones_count_driver_if.sv | 29 ++
 rtl/ones_count_driver.sv | 111 +++++++++++
 2 files changed

// File: rtl/ones_count_driver_if.sv
// Bundle of the three handshakes around the OnesCount driver: upstream word
// source, OnesCount core (d_in_ready/dor), and downstream result consumer.
interface ones_count_driver_if #(
  parameter int W  = 30,
  parameter int CW = $clog2(W + 1)
);
  logic [W-1:0]  src_word;
  logic          src_valid;
  logic          src_ready;
  logic [W-1:0]  d_in;
  logic          d_in_ready;
  logic [CW-1:0] d_out;
  logic          dor;
  logic [CW-1:0] result;
  logic          result_valid;
  logic          result_err;
  logic          result_ack;
  logic          busy;

  modport master (
    input  src_word, src_valid, d_out, dor, result_ack,
    output src_ready, d_in, d_in_ready, result, result_valid, result_err, busy
  );

  modport slave (
    output src_word, src_valid, d_out, dor, result_ack,
    input  src_ready, d_in, d_in_ready, result, result_valid, result_err, busy
  );
endinterface

// File: rtl/ones_count_driver.sv
// Initiator for a OnesCount core: issues one word per transaction, waits for
// dor (bounded by a timeout) and hands the count back with an error flag.
//
// state | meaning
// IDLE  | ready for a new upstream word
// ISSUE | d_in_ready strobe is high for this single cycle
// WAIT  | waiting for dor; timeout timer running
// DONE  | result presented, held until result_ack
module ones_count_driver #(
  parameter int W       = 30,
  parameter int CW      = $clog2(W + 1),
  parameter int TIMEOUT = 64
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  ones_count_driver_if.master  bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  d_in_q, d_in_d;
  logic          d_in_ready_q, d_in_ready_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          result_err_q, result_err_d;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q        <= S_IDLE;
      d_in_q         <= '0;
      d_in_ready_q   <= 1'b0;
      timer_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      d_in_q         <= d_in_d;
      d_in_ready_q   <= d_in_ready_d;
      timer_q        <= timer_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_err_q   <= result_err_d;
    end
  end

  // Timer is a down-counter loaded in ISSUE; reaching zero marks the last
  // permitted WAIT cycle, so WAIT lasts at most TIMEOUT cycles.
  always_comb begin
    state_d        = state_q;
    d_in_d         = d_in_q;
    d_in_ready_d   = 1'b0;
    timer_d        = timer_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    result_err_d   = result_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.src_valid) begin
          d_in_d       = bus.src_word;
          d_in_ready_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = TW'(TIMEOUT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.dor) begin
          result_d       = bus.d_out;
          result_err_d   = (32'(bus.d_out) > 32'(W));
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end else if (timer_q == '0) begin
          result_d       = '0;
          result_err_d   = 1'b1;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DONE: begin
        if (bus.result_ack) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.src_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.d_in         = d_in_q;
  assign bus.d_in_ready   = d_in_ready_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_err   = result_err_q;

endmodule
